// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller.
// Optional build macro: DMEM_FWD_EN (write-first RAM behaviour).
package dmem_pkg;

  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_ADDR_W = 12;

  localparam logic [DMEM_DATA_W-1:0] DMEM_ZERO = '0;

  // RAM ownership: host loads/dumps, processor runs.
  typedef enum logic {
    HOST = 1'b0,
    RUN  = 1'b1
  } dmem_state_e;

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Processor and host bus of the data-memory controller.
// slave = controller side, master = processor/host side.
// Optional build macro: DMEM_FWD_EN (not referenced here).
interface data_mem_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
);

  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_we;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_hold;
  logic              cpu_done;
  logic              start;
  logic              host_valid;
  logic              host_ready;
  logic              host_wr;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;
  logic              addr_err;

  modport slave (
    input  cpu_addr, cpu_we, cpu_wdata, cpu_done, start,
    input  host_valid, host_wr, host_addr, host_wdata,
    output cpu_rdata, cpu_hold, host_ready, host_rvalid, host_rdata, addr_err
  );

  modport master (
    output cpu_addr, cpu_we, cpu_wdata, cpu_done, start,
    output host_valid, host_wr, host_addr, host_wdata,
    input  cpu_rdata, cpu_hold, host_ready, host_rvalid, host_rdata, addr_err
  );

endinterface

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM with registered read data.
// Optional build macro: DMEM_FWD_EN -> write-first (a read of the address
// being written returns the new data); otherwise read-first.
module dmem_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4096,
  parameter int IDX_W  = 12
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_q
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_q;

  // Array write and registered read; contents are never reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
`ifdef DMEM_FWD_EN
    r_q <= i_we ? i_wdata : r_mem[i_addr];
`else
    r_q <= r_mem[i_addr];
`endif
  end

  assign o_q = r_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: owns the data RAM, serves processor loads/stores
// in RUN and host preload/dump traffic in HOST, holding the processor while
// the host owns the RAM.
// Optional build macro: DMEM_FWD_EN (write-first RAM, see dmem_ram).
import dmem_pkg::*;

module data_mem_ctrl #(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DEPTH  = 4096
) (
  input  logic            clk,
  input  logic            rst,
  data_mem_ctrl_if.slave  bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [DATA_W-1:0] ZERO_W = DATA_W'(DMEM_ZERO);

  dmem_state_e       r_state;
  dmem_state_e       w_state_nxt;
  logic              w_run;
  logic              w_host_acc;
  logic              w_cpu_oor;
  logic              w_host_oor;
  logic              w_err_set;
  logic              w_ram_we;
  logic [IDX_W-1:0]  w_ram_addr;
  logic [DATA_W-1:0] w_ram_wdata;
  logic [DATA_W-1:0] w_ram_q;
  logic [DATA_W-1:0] w_cpu_rdata;
  logic [DATA_W-1:0] w_host_rdata;

  logic              r_cpu_lat;
  logic              r_cpu_oor;
  logic              r_host_rvalid;
  logic              r_host_oor;
  logic              r_addr_err;
  logic [DATA_W-1:0] r_cpu_keep;
  logic [DATA_W-1:0] r_host_keep;

  assign w_run      = (r_state == RUN);
  assign w_host_acc = !w_run && bus.host_valid;
  assign w_cpu_oor  = {1'b0, bus.cpu_addr}  >= DEPTH_C;
  assign w_host_oor = {1'b0, bus.host_addr} >= DEPTH_C;

  // Ownership state register; reset returns the RAM to the host at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= HOST;
    else      r_state <= w_state_nxt;
  end

  // Next ownership: start hands over, cpu_done returns; each ignored elsewhere.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      HOST:    if (bus.start)    w_state_nxt = RUN;
      RUN:     if (bus.cpu_done) w_state_nxt = HOST;
      default: w_state_nxt = HOST;
    endcase
  end

  // RAM port mux by owner; out-of-range writes never reach the array.
  always_comb begin
    w_ram_addr  = bus.host_addr[IDX_W-1:0];
    w_ram_wdata = bus.host_wdata;
    w_ram_we    = w_host_acc && bus.host_wr && !w_host_oor;
    if (w_run) begin
      w_ram_addr  = bus.cpu_addr[IDX_W-1:0];
      w_ram_wdata = bus.cpu_wdata;
      w_ram_we    = bus.cpu_we && !w_cpu_oor;
    end
  end

  dmem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_q     (w_ram_q)
  );

  assign w_err_set = w_run ? w_cpu_oor : (w_host_acc && w_host_oor);

  // Read bookkeeping: which port the RAM output belongs to, range flags,
  // held copies of both read buses, and the sticky range-error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cpu_lat     <= 1'b0;
      r_cpu_oor     <= 1'b0;
      r_host_rvalid <= 1'b0;
      r_host_oor    <= 1'b0;
      r_addr_err    <= 1'b0;
      r_cpu_keep    <= ZERO_W;
      r_host_keep   <= ZERO_W;
    end else begin
      r_cpu_lat     <= w_run;
      r_cpu_oor     <= w_cpu_oor;
      r_host_rvalid <= w_host_acc && !bus.host_wr;
      r_host_oor    <= w_host_oor;
      r_cpu_keep    <= w_cpu_rdata;
      r_host_keep   <= w_host_rdata;
      if (w_err_set)                 r_addr_err <= 1'b1;
      else if (!w_run && bus.start)  r_addr_err <= 1'b0;
    end
  end

  // Fresh RAM data is shown for one cycle after a read; otherwise the
  // previous value is held so host traffic never disturbs cpu_rdata.
  always_comb begin
    w_cpu_rdata  = r_cpu_keep;
    w_host_rdata = r_host_keep;
    if (r_cpu_lat)     w_cpu_rdata  = r_cpu_oor  ? ZERO_W : w_ram_q;
    if (r_host_rvalid) w_host_rdata = r_host_oor ? ZERO_W : w_ram_q;
  end

  assign bus.cpu_rdata   = w_cpu_rdata;
  assign bus.cpu_hold    = !w_run;
  assign bus.host_ready  = !w_run;
  assign bus.host_rvalid = r_host_rvalid;
  assign bus.host_rdata  = w_host_rdata;
  assign bus.addr_err    = r_addr_err;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed + randomized bench for data_mem_ctrl (full-depth and DEPTH=16).
// Honours DMEM_FWD_EN for same-cycle store/load expectations.
module tb_data_mem_ctrl;
  import dmem_pkg::*;

  localparam int AW = 12;
  localparam int DW = 32;
`ifdef DMEM_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_mem_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bif ();
  data_mem_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bsm ();

  data_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(4096)) dut (
    .clk (clk), .rst (rst), .bus (bif.slave));
  data_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(16)) dut16 (
    .clk (clk), .rst (rst), .bus (bsm.slave));

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] m [4096];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic hwrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bif.host_valid = 1'b1; bif.host_wr = 1'b1;
    bif.host_addr = a; bif.host_wdata = d;
    tick();
    bif.host_valid = 1'b0; bif.host_wr = 1'b0;
    m[a] = d;
  endtask

  task automatic hread(input logic [AW-1:0] a, input string tag);
    bif.host_valid = 1'b1; bif.host_wr = 1'b0; bif.host_addr = a;
    tick();
    bif.host_valid = 1'b0;
    chk({tag, "_rvalid"}, DW'(bif.host_rvalid), 1);
    chk(tag, bif.host_rdata, m[a]);
  endtask

  // Processor access; load data expected on the following cycle.
  task automatic cpu_op(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] d,
                        input string tag);
    logic [DW-1:0] e;
    bif.cpu_addr = a; bif.cpu_we = we; bif.cpu_wdata = d;
    e = (we && FWD) ? d : m[a];
    if (we) m[a] = d;
    tick();
    bif.cpu_we = 1'b0;
    chk(tag, bif.cpu_rdata, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] ra, rb;
    logic [DW-1:0] rd;
    logic          rw;

    bif.cpu_addr = '0; bif.cpu_we = 0; bif.cpu_wdata = '0; bif.cpu_done = 0;
    bif.start = 0; bif.host_valid = 0; bif.host_wr = 0; bif.host_addr = '0;
    bif.host_wdata = '0;
    bsm.cpu_addr = '0; bsm.cpu_we = 0; bsm.cpu_wdata = '0; bsm.cpu_done = 0;
    bsm.start = 0; bsm.host_valid = 0; bsm.host_wr = 0; bsm.host_addr = '0;
    bsm.host_wdata = '0;

    // Reset values
    #12;
    chk("rst_hold",   DW'(bif.cpu_hold), 1);
    chk("rst_ready",  DW'(bif.host_ready), 1);
    chk("rst_cpu_rd", bif.cpu_rdata, 0);
    chk("rst_host_rd", bif.host_rdata, 0);
    chk("rst_rvalid", DW'(bif.host_rvalid), 0);
    chk("rst_err",    DW'(bif.addr_err), 0);
    rst = 1'b1;
    tick();

    // Host preload and readback
    hwrite(12'd5, 32'h0000_0011);
    hwrite(12'd6, 32'h0000_0022);
    hwrite(12'd7, 32'h0000_0077);
    hwrite(12'd8, 32'h0000_0088);
    hwrite(12'd9, 32'h0000_0099);
    for (int i = 16; i < 80; i++) hwrite(AW'(i), $urandom);
    hread(12'd6, "h_rd6");
    tick();
    chk("h_rvalid_pulse", DW'(bif.host_rvalid), 0);
    chk("h_rdata_hold", bif.host_rdata, 32'h22);

    // cpu_done ignored in HOST; start wins over simultaneous cpu_done
    bif.cpu_done = 1'b1; tick(); bif.cpu_done = 1'b0;
    chk("done_in_host", DW'(bif.cpu_hold), 1);
    bif.start = 1'b1; bif.cpu_done = 1'b1; tick();
    bif.start = 1'b0; bif.cpu_done = 1'b0;
    chk("start_wins_hold", DW'(bif.cpu_hold), 0);
    chk("start_wins_ready", DW'(bif.host_ready), 0);
    bif.cpu_done = 1'b1; tick(); bif.cpu_done = 1'b0;
    chk("back_to_host", DW'(bif.cpu_hold), 1);

    // RUN: processor loads/stores while a host read waits
    bif.start = 1'b1; tick(); bif.start = 1'b0;
    chk("run_hold", DW'(bif.cpu_hold), 0);
    cpu_op(12'd5, 1'b0, '0, "cpu_rd5");
    bif.host_valid = 1'b1; bif.host_wr = 1'b0; bif.host_addr = 12'd6;
    cpu_op(12'd7, 1'b1, 32'hDEAD_BEEF, "cpu_st7_same");
    chk("run_ready", DW'(bif.host_ready), 0);
    cpu_op(12'd7, 1'b0, '0, "cpu_rd7_after");
    chk("run_no_rvalid", DW'(bif.host_rvalid), 0);
    for (int i = 0; i < 40; i++) begin
      ra = AW'($urandom_range(16, 79));
      rw = 1'($urandom_range(0, 1));
      rd = $urandom;
      cpu_op(ra, rw, rd, "cpu_rand");
    end
    chk("run_ready_late", DW'(bif.host_ready), 0);
    chk("run_err", DW'(bif.addr_err), 0);

    // Store in the cpu_done cycle; waiting host read then accepted
    bif.cpu_done = 1'b1;
    cpu_op(12'd8, 1'b1, 32'h55, "cpu_st8_done");
    bif.cpu_done = 1'b0;
    chk("done_hold", DW'(bif.cpu_hold), 1);
    chk("done_ready", DW'(bif.host_ready), 1);
    chk("done_no_rvalid", DW'(bif.host_rvalid), 0);
    rd = FWD ? 32'h55 : 32'h88;
    tick();
    bif.host_valid = 1'b0;
    chk("wait_rvalid", DW'(bif.host_rvalid), 1);
    chk("wait_rdata", bif.host_rdata, 32'h22);
    chk("cpu_rdata_kept", bif.cpu_rdata, rd);
    hread(12'd8, "h_rd8");
    for (int i = 0; i < 6; i++) hread(AW'($urandom_range(16, 79)), "h_rand");

    // Back-to-back host reads
    ra = AW'($urandom_range(16, 79));
    rb = AW'($urandom_range(16, 79));
    bif.host_valid = 1'b1; bif.host_wr = 1'b0; bif.host_addr = ra;
    tick();
    chk("b2b_rv0", DW'(bif.host_rvalid), 1);
    chk("b2b_d0", bif.host_rdata, m[ra]);
    bif.host_addr = rb;
    tick();
    bif.host_valid = 1'b0;
    chk("b2b_rv1", DW'(bif.host_rvalid), 1);
    chk("b2b_d1", bif.host_rdata, m[rb]);
    tick();
    chk("b2b_rv_end", DW'(bif.host_rvalid), 0);

    // DEPTH=16 instance: out-of-range handling
    bsm.host_valid = 1'b1; bsm.host_wr = 1'b1;
    bsm.host_addr = 12'd4; bsm.host_wdata = 32'h44;
    tick();
    chk("s_err_inrange", DW'(bsm.addr_err), 0);
    bsm.host_addr = 12'd20; bsm.host_wdata = 32'h0BAD;
    tick();
    bsm.host_wr = 1'b0;
    chk("s_err_set", DW'(bsm.addr_err), 1);
    bsm.host_addr = 12'd4;
    tick();
    chk("s_rd4_rvalid", DW'(bsm.host_rvalid), 1);
    chk("s_rd4_alias", bsm.host_rdata, 32'h44);
    bsm.host_addr = 12'd20;
    tick();
    bsm.host_valid = 1'b0;
    chk("s_rd20_rvalid", DW'(bsm.host_rvalid), 1);
    chk("s_rd20_zero", bsm.host_rdata, 0);
    bsm.cpu_addr = 12'd0; bsm.start = 1'b1;
    tick();
    bsm.start = 1'b0;
    chk("s_err_clear", DW'(bsm.addr_err), 0);
    chk("s_run_hold", DW'(bsm.cpu_hold), 0);
    bsm.cpu_done = 1'b1; tick(); bsm.cpu_done = 1'b0;
    chk("s_host_hold", DW'(bsm.cpu_hold), 1);

    // Reset in the middle of RUN with a store in flight
    bif.start = 1'b1; tick(); bif.start = 1'b0;
    cpu_op(12'd5, 1'b0, '0, "mid_rd5");
    bif.cpu_addr = 12'd9; bif.cpu_we = 1'b1; bif.cpu_wdata = 32'hCAFE_F00D;
    rst = 1'b0;
    #1;
    chk("mid_rst_hold", DW'(bif.cpu_hold), 1);
    chk("mid_rst_rvalid", DW'(bif.host_rvalid), 0);
    chk("mid_rst_cpu_rd", bif.cpu_rdata, 0);
    tick();
    bif.cpu_we = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    hread(12'd5, "post_rst5");
    hread(12'd7, "post_rst7");
    hread(12'd9, "post_rst9");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
